q_step_responder: RTL
=====================

Name: q_step_responder

Overview:
- Agent-side responder for the grid-world control unit's step handshake.
- The control unit raises step_req with the resulting state, reward and terminal flag.
- The block then:
  - updates its Q-table entry for the previous (state, action) pair;
  - picks the next action epsilon-greedily;
  - returns that action with a one-cycle step_ack.
- It holds a 25-state x 4-action signed Q-table and an internal LFSR for exploration.

Parameters:
- ALPHA_SHIFT, 2, learning rate = 2^-ALPHA_SHIFT.
- GAMMA_SHIFT, 3, discount = 1 - 2^-GAMMA_SHIFT.
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- step_req  input  1  step request; sampled only in IDLE.
- start  input  1  qualifies step_req: next_state begins a new episode, so no Q update is made.
- next_state  input  6  state reached; valid values 1..25, index = state-1.
- next_reward  input  16  signed reward for reaching next_state.
- terminal  input  1  next_state is a hole or goal; its future value is taken as 0.
- epsilon  input  16  unsigned exploration threshold.
- step_ack  output  1  one-cycle pulse; next_action is valid from this cycle.
- next_action  output  4  one-hot action: 0001 up, 0010 down, 0100 left, 1000 right.
- busy  output  1  high in every state except IDLE.
- q_rd_state  input  6  debug read, state.
- q_rd_action  input  2  debug read, action index.
- q_rd_data  output  16  combinational Q[q_rd_state-1][q_rd_action]; 0 if the state is out of range.

Behaviour:
- Reset (synchronous, active-high):
  - all 100 Q entries cleared to 0; step_ack=0, next_action=4'b0000, busy=0;
  - prev_valid=0, LFSR=LFSR_SEED, FSM=IDLE.
- Reset asserted in any state aborts the step: no Q write, no ack.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every clock when not in reset.
- FSM: IDLE -> SCAN0..SCAN3 -> UPD -> SEL -> ACK -> IDLE.
  - IDLE: on step_req=1, latch start, next_state, next_reward, terminal and epsilon, then go to SCAN0. Held inputs are not re-sampled.
  - SCANk (k=0..3): compare Q[s'][k] and track maxq and argmax.
    - Strictly-greater replaces, so ties resolve to the lowest index.
    - If terminal=1 or s' is out of range: maxq=0, argmax=0.
  - UPD: if prev_valid=1 and latched start=0, write Q[prev_s][prev_a].
    - Arithmetic is 18-bit signed:
      - target = r + maxq - (maxq >>> GAMMA_SHIFT);
      - delta = target - Q;
      - Qn = Q + (delta >>> ALPHA_SHIFT).
    - Qn saturates to [-32768, 32767].
    - Shifts are arithmetic and round toward minus infinity.
  - SEL: action choice, using the LFSR value present in this cycle.
    - Explore if lfsr < epsilon (unsigned): action index = lfsr[1:0].
    - Otherwise action index = argmax.
    - Register next_action as one-hot.
    - prev_s <= s', prev_a <= index.
    - prev_valid <= 1, unless terminal=1 or s' is out of range; then prev_valid <= 0.
  - ACK: step_ack=1 for exactly this cycle, then return to IDLE.
- Latency:
  - If step_req is sampled high at edge E0, step_ack is high during the cycle after edge E7.
  - The earliest next request is sampled at E8.
- step_req while busy is ignored and not queued.
- next_action holds its value until the next SEL or reset.
- epsilon=0 gives a purely greedy choice.
- A start=1 step with prev_valid=1 discards the old pair without writing it.
- The debug read port never blocks FSM operation. A same-cycle UPD write shows on q_rd_data from the next cycle.

Test Plan:
1. Reset, then step_req with start=1, next_state=1, epsilon=0 -> step_ack pulses exactly 7 cycles after acceptance; next_action=0001 (all-zero tie); all Q reads 0.
2. Continue from 1 with start=0, next_state=2, reward=+100, terminal=0 -> Q[1][up] reads 25 (100>>>2).
3. Repeat the same transition -> Q[1][up] = 25 + ((100-25)>>>2) = 43. Then preload Q[2][down] to 40 via updates, make the same 1->2 step, and check target = r + 40 - 5 with max over the row of 2 correctly applied.
4. Step into terminal state 5 with reward -100 -> Q[prev][a] decreases by 25; prev_valid clears, so the next step (start=1) writes nothing.
5. epsilon=16'hFFFF -> each action matches a reference LFSR model's lfsr[1:0] over 50 steps; step_req pulses during busy are ignored, with no extra ack.
6. Assert rst during SCAN2 -> no step_ack, Q unchanged, busy=0 next cycle, next_action=0000. Separately, run ALPHA_SHIFT=0 with reward 32767 twice -> the entry saturates at 32767.

Source files
------------

// File: rtl/q_step_responder.sv
// Agent-side step responder: one tabular Q-learning update per step handshake,
// followed by an epsilon-greedy action choice returned with a one-cycle ack.
module q_step_responder #(
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_req,
  input  logic        start,
  input  logic [5:0]  next_state,
  input  logic [15:0] next_reward,
  input  logic        terminal,
  input  logic [15:0] epsilon,
  output logic        step_ack,
  output logic [3:0]  next_action,
  output logic        busy,
  input  logic [5:0]  q_rd_state,
  input  logic [1:0]  q_rd_action,
  output logic [15:0] q_rd_data
);

  typedef enum logic [2:0] {
    IDLE, SCAN0, SCAN1, SCAN2, SCAN3, UPD, SEL, ACK
  } state_t;

  state_t             st;
  logic signed [15:0] q_mem [0:99];
  logic [15:0]        lfsr;

  logic               l_start;
  logic [5:0]         l_ns;
  logic [15:0]        l_reward;
  logic               l_term;
  logic [15:0]        l_eps;

  logic signed [15:0] maxq;
  logic [1:0]         argmax;
  logic [4:0]         prev_s;
  logic [1:0]         prev_a;
  logic               prev_valid;

  logic               ns_ok;
  logic               skip;
  logic [4:0]         ns_idx;
  logic [1:0]         scan_k;
  logic signed [15:0] scan_q;

  logic               rd_ok;
  logic [4:0]         rd_idx;

  logic signed [17:0] r_ext, mq_ext, q_ext;
  logic signed [17:0] target, delta, qn;
  logic signed [15:0] q_sat;

  logic               explore;
  logic [1:0]         sel_idx;

  assign ns_ok  = (l_ns != 6'd0) && (l_ns <= 6'd25);
  assign skip   = l_term || !ns_ok;
  assign ns_idx = 5'(l_ns - 6'd1);

  always_comb begin
    scan_k = 2'd0;
    case (st)
      SCAN1:   scan_k = 2'd1;
      SCAN2:   scan_k = 2'd2;
      SCAN3:   scan_k = 2'd3;
      default: scan_k = 2'd0;
    endcase
  end

  assign scan_q = ns_ok ? q_mem[{ns_idx, scan_k}] : '0;

  assign rd_ok     = (q_rd_state != 6'd0) && (q_rd_state <= 6'd25);
  assign rd_idx    = 5'(q_rd_state - 6'd1);
  assign q_rd_data = rd_ok ? q_mem[{rd_idx, q_rd_action}] : '0;

  // 18 bits hold r + maxq - maxq/8 and the resulting delta without overflow.
  assign r_ext  = {{2{l_reward[15]}}, l_reward};
  assign mq_ext = {{2{maxq[15]}}, maxq};
  assign q_ext  = {{2{q_mem[{prev_s, prev_a}][15]}}, q_mem[{prev_s, prev_a}]};
  assign target = r_ext + mq_ext - (mq_ext >>> GAMMA_SHIFT);
  assign delta  = target - q_ext;
  assign qn     = q_ext + (delta >>> ALPHA_SHIFT);

  always_comb begin
    if (qn > 18'sd32767)
      q_sat = 16'sh7FFF;
    else if (qn < -18'sd32768)
      q_sat = 16'sh8000;
    else
      q_sat = qn[15:0];
  end

  assign explore = lfsr < l_eps;
  assign sel_idx = explore ? lfsr[1:0] : argmax;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 100; i++)
        q_mem[i] <= '0;
      lfsr        <= LFSR_SEED;
      st          <= IDLE;
      step_ack    <= 1'b0;
      next_action <= '0;
      busy        <= 1'b0;
      prev_valid  <= 1'b0;
      prev_s      <= '0;
      prev_a      <= '0;
      maxq        <= '0;
      argmax      <= '0;
      l_start     <= 1'b0;
      l_ns        <= '0;
      l_reward    <= '0;
      l_term      <= 1'b0;
      l_eps       <= '0;
    end else begin
      lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      step_ack <= 1'b0;
      case (st)
        IDLE: begin
          if (step_req) begin
            l_start  <= start;
            l_ns     <= next_state;
            l_reward <= next_reward;
            l_term   <= terminal;
            l_eps    <= epsilon;
            busy     <= 1'b1;
            st       <= SCAN0;
          end
        end
        SCAN0, SCAN1, SCAN2, SCAN3: begin
          if (skip || st == SCAN0) begin
            maxq   <= skip ? 16'sd0 : scan_q;
            argmax <= 2'd0;
          end else if (scan_q > maxq) begin
            maxq   <= scan_q;
            argmax <= scan_k;
          end
          st <= (st == SCAN3) ? UPD : state_t'(st + 3'd1);
        end
        UPD: begin
          if (prev_valid && !l_start)
            q_mem[{prev_s, prev_a}] <= q_sat;
          st <= SEL;
        end
        SEL: begin
          next_action <= 4'b0001 << sel_idx;
          prev_s      <= ns_ok ? ns_idx : 5'd0;
          prev_a      <= sel_idx;
          prev_valid  <= !skip;
          st          <= ACK;
        end
        ACK: begin
          step_ack <= 1'b1;
          busy     <= 1'b0;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
